// File: rtl/pic_ctrl_seq.sv
// Control sequencer for an 8259A-style PIC: ICW1-ICW4 init, OCW1/OCW2
// handling, and the 8086-mode two-pulse INTA cycle feeding the data-bus buffer.
module pic_ctrl_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_flag,
  input  logic       a0,
  input  logic [7:0] din,
  input  logic       inta_n,
  input  logic       irq_valid,
  input  logic [2:0] irq_level,
  output logic       int_out,
  output logic [7:0] dout,
  output logic       dout_en,
  output logic       freeze,
  output logic       isr_set,
  output logic [2:0] isr_level,
  output logic       eoi,
  output logic       eoi_specific,
  output logic [2:0] eoi_level,
  output logic [7:0] imr,
  output logic       ltim,
  output logic       aeoi,
  output logic       init_done
);

  typedef enum logic [2:0] {UNINIT, W_ICW2, W_ICW3, W_ICW4, READY} init_st_t;
  typedef enum logic [1:0] {I_IDLE, I_REQ, I_ACK1, I_ACK2} inta_st_t;

  init_st_t r_init_st, w_init_nx;
  inta_st_t r_inta_st, w_inta_nx;

  logic       r_inta_q;
  logic [4:0] r_base;
  logic       r_sngl, r_ic4, r_ltim, r_aeoi;
  logic [7:0] r_imr;
  logic [2:0] r_lvl;
  logic       r_spur;
  logic       r_isr_set;
  logic [2:0] r_isr_lvl;
  logic       r_eoi, r_eoi_spec;
  logic [2:0] r_eoi_lvl;
  logic       r_aeoi_pend;
  logic [2:0] r_pend_lvl;

  logic w_icw1, w_wr1, w_ocw2, w_ns_eoi, w_sp_eoi, w_fall, w_ready, w_aeoi_evt;

  assign w_icw1     = wr_flag & ~a0 & din[4];
  assign w_wr1      = wr_flag & a0;
  assign w_ready    = (r_init_st == READY);
  assign w_ocw2     = wr_flag & ~a0 & (din[4:3] == 2'b00) & w_ready;
  assign w_ns_eoi   = w_ocw2 & (din[7:5] == 3'b001);
  assign w_sp_eoi   = w_ocw2 & (din[7:5] == 3'b011);
  assign w_fall     = r_inta_q & ~inta_n;
  assign w_aeoi_evt = (r_inta_st == I_ACK2) & inta_n & r_aeoi & ~r_spur & ~w_icw1;

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_init_st <= UNINIT;
      r_inta_st <= I_IDLE;
    end else begin
      r_init_st <= w_init_nx;
      r_inta_st <= w_inta_nx;
    end
  end

  // Init next state; ICW3 carries cascade data a single device never uses,
  // so its slot is only consumed.
  always_comb begin
    w_init_nx = r_init_st;
    if (w_icw1) w_init_nx = W_ICW2;
    else if (w_wr1) begin
      case (r_init_st)
        W_ICW2:  w_init_nx = !r_sngl ? W_ICW3 : (r_ic4 ? W_ICW4 : READY);
        W_ICW3:  w_init_nx = r_ic4 ? W_ICW4 : READY;
        W_ICW4:  w_init_nx = READY;
        default: w_init_nx = r_init_st;
      endcase
    end
  end

  // INTA next state; ICW1 wins over any INTA edge in the same cycle
  always_comb begin
    w_inta_nx = r_inta_st;
    if (w_icw1) w_inta_nx = I_IDLE;
    else begin
      case (r_inta_st)
        I_IDLE: if (w_ready && irq_valid) w_inta_nx = I_REQ;
        I_REQ: begin
          if (w_fall)                   w_inta_nx = I_ACK1;
          else if (!irq_valid && r_ltim) w_inta_nx = I_IDLE;
        end
        I_ACK1:  if (w_fall) w_inta_nx = I_ACK2;
        I_ACK2:  if (inta_n) w_inta_nx = I_IDLE;
        default: w_inta_nx = I_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inta_q    <= 1'b1;
      r_base      <= '0;
      r_sngl      <= 1'b0;
      r_ic4       <= 1'b0;
      r_ltim      <= 1'b0;
      r_aeoi      <= 1'b0;
      r_imr       <= '0;
      r_lvl       <= '0;
      r_spur      <= 1'b0;
      r_isr_set   <= 1'b0;
      r_isr_lvl   <= '0;
      r_eoi       <= 1'b0;
      r_eoi_spec  <= 1'b0;
      r_eoi_lvl   <= '0;
      r_aeoi_pend <= 1'b0;
      r_pend_lvl  <= '0;
    end else begin
      r_inta_q   <= inta_n;
      r_isr_set  <= 1'b0;
      r_isr_lvl  <= '0;
      r_eoi      <= 1'b0;
      r_eoi_spec <= 1'b0;
      r_eoi_lvl  <= '0;
      if (w_icw1) begin
        r_ltim      <= din[3];
        r_sngl      <= din[1];
        r_ic4       <= din[0];
        r_imr       <= '0;
        r_aeoi      <= 1'b0;
        r_aeoi_pend <= 1'b0;
      end else begin
        if (w_wr1) begin
          case (r_init_st)
            W_ICW2:  r_base <= din[7:3];
            W_ICW4:  r_aeoi <= din[1];
            READY:   r_imr  <= din;
            default: ;
          endcase
        end
        if (r_inta_st == I_REQ && w_fall) begin
          r_lvl     <= irq_valid ? irq_level : 3'd7;
          r_spur    <= ~irq_valid;
          r_isr_set <= irq_valid;
          r_isr_lvl <= irq_valid ? irq_level : 3'd0;
        end
        // Explicit OCW2 EOI takes the pulse; a colliding auto-EOI waits a cycle
        if (w_ns_eoi || w_sp_eoi) begin
          r_eoi      <= 1'b1;
          r_eoi_spec <= w_sp_eoi;
          r_eoi_lvl  <= w_sp_eoi ? din[2:0] : 3'd0;
          if (w_aeoi_evt) begin
            r_aeoi_pend <= 1'b1;
            r_pend_lvl  <= r_lvl;
          end
        end else if (r_aeoi_pend || w_aeoi_evt) begin
          r_eoi       <= 1'b1;
          r_eoi_spec  <= 1'b1;
          r_eoi_lvl   <= r_aeoi_pend ? r_pend_lvl : r_lvl;
          r_aeoi_pend <= r_aeoi_pend & w_aeoi_evt;
          r_pend_lvl  <= r_lvl;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    int_out      = (r_inta_st == I_REQ);
    freeze       = (r_inta_st == I_ACK1) || (r_inta_st == I_ACK2);
    dout_en      = (r_inta_st == I_ACK2);
    dout         = dout_en ? {r_base, r_lvl} : 8'h00;
    init_done    = w_ready;
    isr_set      = r_isr_set;
    isr_level    = r_isr_lvl;
    eoi          = r_eoi;
    eoi_specific = r_eoi_spec;
    eoi_level    = r_eoi_lvl;
    imr          = r_imr;
    ltim         = r_ltim;
    aeoi         = r_aeoi;
  end

endmodule

// File: tb/tb_pic_ctrl_seq.sv
// Bench for pic_ctrl_seq: directed vector table, hand-written corner sequences,
// then random traffic compared against a transaction-level model.
module tb_pic_ctrl_seq;
  logic       clk, rst_n, wr_flag, a0, inta_n, irq_valid;
  logic [7:0] din;
  logic [2:0] irq_level;
  logic       int_out, dout_en, freeze, isr_set, eoi, eoi_specific, ltim, aeoi, init_done;
  logic [7:0] dout, imr;
  logic [2:0] isr_level, eoi_level;

  int n_tot = 0, n_pass = 0;

  pic_ctrl_seq dut (
    .clk(clk), .rst_n(rst_n), .wr_flag(wr_flag), .a0(a0), .din(din),
    .inta_n(inta_n), .irq_valid(irq_valid), .irq_level(irq_level),
    .int_out(int_out), .dout(dout), .dout_en(dout_en), .freeze(freeze),
    .isr_set(isr_set), .isr_level(isr_level), .eoi(eoi),
    .eoi_specific(eoi_specific), .eoi_level(eoi_level), .imr(imr),
    .ltim(ltim), .aeoi(aeoi), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input logic io, den, input logic [7:0] dv,
      input logic frz, isr, input logic [2:0] isrl, input logic e, es,
      input logic [2:0] el, input logic done, ae, input logic [7:0] im, input logic lt);
    return {1'b0, io, den, dv, frz, isr, isrl, e, es, el, done, ae, im, lt};
  endfunction

  function automatic logic [31:0] dut_vec();
    return pk(int_out, dout_en, dout, freeze, isr_set, isr_level, eoi,
              eoi_specific, eoi_level, init_done, aeoi, imr, ltim);
  endfunction

  // Reference model: stage 0 = uninitialised, 1..3 = awaiting ICW2..ICW4,
  // 4 = ready; m_ack: -1 no request, 0 INT raised, 1/2 INTA pulses seen.
  int         m_stage, m_ack;
  bit         m_sngl, m_ic4, m_ltim, m_aeoi, m_spur, m_prev;
  bit [4:0]   m_base;
  bit [7:0]   m_imr;
  bit [2:0]   m_lvl, m_isrl, m_el;
  bit         m_isr, m_eoi, m_es;
  bit [2:0]   q_eoi[$];

  function automatic logic [31:0] model_vec();
    return pk(m_ack == 0, m_ack == 2, (m_ack == 2) ? {m_base, m_lvl} : 8'h00,
              m_ack >= 1, m_isr, m_isrl, m_eoi, m_es, m_el, m_stage == 4,
              m_aeoi, m_imr, m_ltim);
  endfunction

  task automatic model_step();
    bit fall, icw1, ready, ev;
    m_isr = 0; m_isrl = 0; m_eoi = 0; m_es = 0; m_el = 0;
    if (!rst_n) begin
      m_stage = 0; m_ack = -1; m_sngl = 0; m_ic4 = 0; m_ltim = 0; m_aeoi = 0;
      m_spur = 0; m_prev = 1; m_base = 0; m_imr = 0; m_lvl = 0;
      q_eoi.delete();
      return;
    end
    fall  = m_prev && !inta_n;
    m_prev = inta_n;
    icw1  = wr_flag && !a0 && din[4];
    ready = (m_stage == 4);
    if (icw1) begin
      m_ltim = din[3]; m_sngl = din[1]; m_ic4 = din[0];
      m_imr = 0; m_aeoi = 0; m_stage = 1; m_ack = -1;
      q_eoi.delete();
      return;
    end
    ev = (m_ack == 2) && inta_n && m_aeoi && !m_spur;
    if (wr_flag && a0) begin
      case (m_stage)
        1: begin m_base = din[7:3]; m_stage = !m_sngl ? 2 : (m_ic4 ? 3 : 4); end
        2: m_stage = m_ic4 ? 3 : 4;
        3: begin m_aeoi = din[1]; m_stage = 4; end
        4: m_imr = din;
        default: ;
      endcase
    end
    case (m_ack)
      -1: if (ready && irq_valid) m_ack = 0;
      0: begin
        if (fall) begin
          m_ack = 1; m_spur = !irq_valid;
          m_lvl = irq_valid ? irq_level : 3'd7;
          m_isr = irq_valid; m_isrl = irq_valid ? irq_level : 3'd0;
        end else if (!irq_valid && m_ltim) m_ack = -1;
      end
      1: if (fall) m_ack = 2;
      2: if (inta_n) m_ack = -1;
      default: ;
    endcase
    if (ev) q_eoi.push_back(m_lvl);
    if (ready && wr_flag && !a0 && din[4:3] == 2'b00 &&
        (din[7:5] == 3'd1 || din[7:5] == 3'd3)) begin
      m_eoi = 1; m_es = (din[7:5] == 3'd3); m_el = m_es ? din[2:0] : 3'd0;
    end else if (q_eoi.size() > 0) begin
      m_eoi = 1; m_es = 1; m_el = q_eoi.pop_front();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drv(input logic w, a, input logic [7:0] d, input logic in, v,
                     input logic [2:0] l);
    wr_flag = w; a0 = a; din = d; inta_n = in; irq_valid = v; irq_level = l;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic init3(input logic [7:0] c1, c2, c4);
    drv(1, 0, c1, 1, 0, 0); tick();
    drv(1, 1, c2, 1, 0, 0); tick();
    drv(1, 1, c4, 1, 0, 0); tick();
    drv(0, 0, 0, 1, 0, 0);
  endtask

  typedef struct {
    logic       wr, a0;
    logic [7:0] d;
    logic       inta, iv;
    logic [2:0] il;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[21];

  initial begin
    // args of pk: int,den,dout,frz,isr,isrl,eoi,es,el,done,aeoi,imr,ltim
    tbl[0]  = '{1, 0, 8'h13, 1, 0, 0, pk(0,0,8'h00,0,0,0,0,0,0,0,0,8'h00,0)};
    tbl[1]  = '{1, 1, 8'h48, 1, 0, 0, pk(0,0,8'h00,0,0,0,0,0,0,0,0,8'h00,0)};
    tbl[2]  = '{1, 1, 8'h03, 1, 0, 0, pk(0,0,8'h00,0,0,0,0,0,0,1,1,8'h00,0)};
    tbl[3]  = '{0, 0, 8'h00, 1, 1, 3, pk(1,0,8'h00,0,0,0,0,0,0,1,1,8'h00,0)};
    tbl[4]  = '{0, 0, 8'h00, 0, 1, 3, pk(0,0,8'h00,1,1,3,0,0,0,1,1,8'h00,0)};
    tbl[5]  = '{0, 0, 8'h00, 1, 1, 3, pk(0,0,8'h00,1,0,0,0,0,0,1,1,8'h00,0)};
    tbl[6]  = '{0, 0, 8'h00, 0, 1, 3, pk(0,1,8'h4B,1,0,0,0,0,0,1,1,8'h00,0)};
    tbl[7]  = '{0, 0, 8'h00, 0, 1, 3, pk(0,1,8'h4B,1,0,0,0,0,0,1,1,8'h00,0)};
    tbl[8]  = '{0, 0, 8'h00, 1, 0, 3, pk(0,0,8'h00,0,0,0,1,1,3,1,1,8'h00,0)};
    tbl[9]  = '{0, 0, 8'h00, 1, 0, 0, pk(0,0,8'h00,0,0,0,0,0,0,1,1,8'h00,0)};
    tbl[10] = '{1, 0, 8'h62, 1, 0, 0, pk(0,0,8'h00,0,0,0,1,1,2,1,1,8'h00,0)};
    tbl[11] = '{1, 1, 8'hA5, 1, 0, 0, pk(0,0,8'h00,0,0,0,0,0,0,1,1,8'hA5,0)};
    tbl[12] = '{1, 0, 8'h20, 1, 0, 0, pk(0,0,8'h00,0,0,0,1,0,0,1,1,8'hA5,0)};
    tbl[13] = '{1, 0, 8'h08, 1, 0, 0, pk(0,0,8'h00,0,0,0,0,0,0,1,1,8'hA5,0)};
    tbl[14] = '{1, 0, 8'hA0, 1, 0, 0, pk(0,0,8'h00,0,0,0,0,0,0,1,1,8'hA5,0)};
    tbl[15] = '{0, 0, 8'h00, 1, 1, 5, pk(1,0,8'h00,0,0,0,0,0,0,1,1,8'hA5,0)};
    tbl[16] = '{0, 0, 8'h00, 1, 0, 5, pk(1,0,8'h00,0,0,0,0,0,0,1,1,8'hA5,0)};
    tbl[17] = '{0, 0, 8'h00, 0, 0, 5, pk(0,0,8'h00,1,0,0,0,0,0,1,1,8'hA5,0)};
    tbl[18] = '{0, 0, 8'h00, 1, 0, 5, pk(0,0,8'h00,1,0,0,0,0,0,1,1,8'hA5,0)};
    tbl[19] = '{0, 0, 8'h00, 0, 0, 5, pk(0,1,8'h4F,1,0,0,0,0,0,1,1,8'hA5,0)};
    tbl[20] = '{0, 0, 8'h00, 1, 0, 5, pk(0,0,8'h00,0,0,0,0,0,0,1,1,8'hA5,0)};

    rst_n = 0; drv(0, 0, 0, 1, 0, 0);
    tick(); tick();
    chk("reset", dut_vec(), 32'h0);
    rst_n = 1;

    for (int i = 0; i < 21; i++) begin
      drv(tbl[i].wr, tbl[i].a0, tbl[i].d, tbl[i].inta, tbl[i].iv, tbl[i].il);
      tick();
      chk($sformatf("table[%0d]", i), dut_vec(), tbl[i].exp);
    end

    // ICW1 between the two INTA pulses, coinciding with the second edge
    drv(0, 0, 0, 1, 1, 3); tick();
    drv(0, 0, 0, 0, 1, 3); tick();
    drv(0, 0, 0, 1, 1, 3); tick();
    drv(1, 0, 8'h13, 0, 1, 3); tick();
    chk("icw1_mid_inta", {int_out, freeze, dout_en, init_done, isr_set, imr, aeoi},
        {5'b0, 8'h00, 1'b0});
    drv(0, 0, 0, 0, 1, 3); tick();
    chk("icw1_edge_dropped", {int_out, dout_en, freeze}, 3'b000);
    drv(1, 1, 8'h48, 0, 1, 3); tick();
    drv(1, 1, 8'h03, 1, 0, 0); tick();
    chk("reinit_done", {init_done, aeoi}, 2'b11);

    // OCW2 EOI colliding with auto-EOI
    drv(0, 0, 0, 1, 1, 3); tick();
    drv(0, 0, 0, 0, 1, 3); tick();
    drv(0, 0, 0, 1, 1, 3); tick();
    drv(0, 0, 0, 0, 1, 3); tick();
    chk("vector_on_bus", {dout_en, dout}, {1'b1, 8'h4B});
    drv(1, 0, 8'h61, 1, 0, 0); tick();
    chk("eoi_collide_ocw2", {eoi, eoi_specific, eoi_level, dout_en}, {1'b1, 1'b1, 3'd1, 1'b0});
    drv(0, 0, 0, 1, 0, 0); tick();
    chk("eoi_deferred_auto", {eoi, eoi_specific, eoi_level}, {1'b1, 1'b1, 3'd3});
    tick();
    chk("eoi_quiet", {eoi, int_out}, 2'b00);

    // Reset while the vector is on the bus
    drv(0, 0, 0, 1, 1, 6); tick();
    drv(0, 0, 0, 0, 1, 6); tick();
    drv(0, 0, 0, 1, 1, 6); tick();
    drv(0, 0, 0, 0, 1, 6); tick();
    chk("den_before_reset", {dout_en, dout}, {1'b1, 8'h4E});
    rst_n = 0; drv(0, 0, 0, 0, 0, 0); tick();
    chk("reset_mid_inta", dut_vec(), 32'h0);
    rst_n = 1;

    // Level-triggered request withdrawn before INTA
    init3(8'h1B, 8'h48, 8'h01);
    tick();
    chk("ltim_init", {ltim, aeoi, init_done}, 3'b101);
    drv(0, 0, 0, 1, 1, 2); tick();
    chk("ltim_int_up", int_out, 1'b1);
    drv(0, 0, 0, 1, 0, 2); tick();
    chk("ltim_int_drop", int_out, 1'b0);

    // Cascade init path consumes the ICW3 slot
    drv(1, 0, 8'h11, 1, 0, 0); tick();
    drv(1, 1, 8'h48, 1, 0, 0); tick();
    chk("icw3_wait", init_done, 1'b0);
    drv(1, 1, 8'h00, 1, 0, 0); tick();
    chk("icw4_wait", init_done, 1'b0);
    drv(1, 0, 8'h02, 1, 0, 0); tick();
    chk("a0_low_ignored", init_done, 1'b0);
    drv(1, 1, 8'h00, 1, 0, 0); tick();
    chk("cascade_done", {init_done, aeoi, imr}, {2'b10, 8'h00});
    drv(1, 1, 8'h3C, 1, 0, 0); tick();
    chk("ocw1_imr", imr, 8'h3C);

    drv(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 399) != 0);
      wr_flag   = ($urandom_range(0, 5) == 0);
      a0        = 1'($urandom_range(0, 1));
      din       = 8'($urandom);
      if (!a0 && $urandom_range(0, 3) != 0) din[4] = 1'b0;
      if ($urandom_range(0, 3) == 0) inta_n = ~inta_n;
      if ($urandom_range(0, 7) == 0) irq_valid = ~irq_valid;
      irq_level = 3'($urandom);
      tick();
      chk($sformatf("random[%0d]", i), dut_vec(), model_vec());
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
